proto_tx: RTL and testbench
===========================

// Module: proto_tx
// PURPOSE
//  Frame transmitter for the host byte-link protocol: [0xAA][TYPE][LEN][PAYLOAD x LEN][CHK].
//  CHK = (TYPE + LEN + sum(PAYLOAD)) mod 256.
//  Takes one packet (type, len, packed payload) from the command/response logic.
//  Emits the frame one byte at a time to the UART transmitter over a valid/ready byte interface.
//  Mirror of the frame receiver; a loopback through both must reproduce the packet exactly.
// PARAMETERS
//  MAX_LEN  32  max payload bytes; payload_bus width = 8*MAX_LEN; legal LEN = 1..MAX_LEN
// PORTS
//  clk          in   1          single clock; all logic on posedge
//  rst          in   1          reset, synchronous, active-high
//  send_valid   in   1          packet request; fields below valid while high
//  send_ready   out  1          high only in IDLE; request accepted when send_valid & send_ready
//  pkt_type     in   8          TYPE byte
//  pkt_len      in   8          LEN byte (payload count)
//  payload_bus  in   8*MAX_LEN  payload, MSB-first: byte k at [8*(MAX_LEN-1-k) +: 8]
//  tx_data      out  8          outgoing frame byte
//  tx_valid     out  1          tx_data valid
//  tx_ready     in   1          UART consumes byte when tx_valid & tx_ready
//  pkt_done     out  1          1-cycle pulse: CHK byte consumed
//  pkt_err      out  1          1-cycle pulse: request rejected (bad LEN)
// BEHAVIOUR
//  Reset (rst high at posedge):
//   - state=IDLE; tx_valid=0, tx_data=0, pkt_done=0, pkt_err=0, send_ready=1.
//   - Internal type/len/payload/sum/idx cleared.
//   - Mid-frame reset aborts the frame; no further bytes and no pkt_done.
//  States: IDLE -> SOF -> TYPE -> LEN -> PAY -> CHK -> IDLE.
//  Accept (IDLE, send_valid=1):
//   - Registers pkt_type, pkt_len, payload_bus.
//   - LEN==0 or LEN>MAX_LEN: pkt_err pulses next cycle, stay IDLE, no bytes emitted.
//   - Otherwise -> SOF; tx_valid=1, tx_data=8'hAA on the cycle after accept (1-cycle latency).
//  Byte advance:
//   - Only on tx_valid & tx_ready; next byte presented the following cycle (tx_valid stays high).
//   - Sequence: AA, TYPE, LEN, payload[0..LEN-1], CHK.
//   - tx_data and tx_valid held stable while tx_ready=0; no byte dropped or repeated.
//  PAY:
//   - idx 8-bit, starts at 0; emits byte idx; increments on handshake.
//   - Leaves for CHK when idx+1==LEN at handshake.
//  Checksum:
//   - 8-bit running sum, wraps mod 256.
//   - Loaded with TYPE, then adds LEN and each payload byte as it is emitted.
//   - CHK byte = final sum.
//  CHK handshake: tx_valid drops the next cycle; pkt_done pulses that cycle; state=IDLE, send_ready=1.
//   - Next request may be accepted the same cycle pkt_done is high.
//   - Minimum gap between frames: 1 idle cycle.
//  send_valid while busy: ignored (send_ready=0); input field changes during a frame have no effect.
//  tx_ready high with tx_valid low: no effect.
//  Throughput: one byte per cycle when tx_ready is held high; frame = LEN+4 bytes.
// STRUCTURE
//  Shared package proto_pkg:
//   - SOF_BYTE = 8'hAA.
//   - State enum (IDLE, SOF, TYPE, LEN, PAY, CHK).
//   - MAX_LEN default, shared with the receiver.
//  No sub-module: the payload byte select (indexed part-select) and the checksum adder stay inline.
// TESTING
//  1 Basic: TYPE=01 LEN=02 payload 10,20, tx_ready=1
//     -> AA 01 02 10 20 33 on consecutive cycles; pkt_done once.
//  2 Backpressure: same packet, tx_ready toggled pseudo-randomly
//     -> identical byte sequence; tx_data stable whenever tx_valid & !tx_ready.
//  3 Checksum wrap: TYPE=FF LEN=01 payload 02 -> AA FF 01 02 02.
//  4 Bad length: LEN=00, then LEN=33 (MAX_LEN=32)
//     -> pkt_err pulse each time; tx_valid never asserts; send_ready stays 1.
//  5 Full/loopback: LEN=32, payload 00..1F, output fed into the frame receiver
//     -> receiver pkt_ready, TYPE/LEN/payload match; back-to-back second frame accepted on the pkt_done cycle.
//  6 Reset mid-frame: rst after the 3rd payload byte
//     -> next cycle tx_valid=0, no pkt_done; a subsequent frame transmits correctly.

Source files
------------

// File: rtl/proto_pkg.sv
// Shared definitions for the host byte-link frame transmitter and receiver.
// Frame layout: [SOF][TYPE][LEN][PAYLOAD x LEN][CHK].
package proto_pkg;

    localparam logic [7:0] SOF_BYTE    = 8'hAA;
    localparam int         DEF_MAX_LEN = 32;

    typedef enum logic [2:0] {
        IDLE,
        SOF,
        TYPE,
        LEN,
        PAY,
        CHK
    } tx_state_t;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/proto_tx.sv
// Frame transmitter: latches one packet and streams it byte-by-byte over a
// valid/ready link as SOF, TYPE, LEN, payload, running-sum checksum.
module proto_tx
    import proto_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 send_valid,
    output logic                 send_ready,
    input  logic [7:0]           pkt_type,
    input  logic [7:0]           pkt_len,
    input  logic [8*MAX_LEN-1:0] payload_bus,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 pkt_done,
    output logic                 pkt_err
);

    localparam int PW = 8 * MAX_LEN;

    tx_state_t      state, state_d;
    logic [7:0]     type_q, len_q, sum_q, idx_q;
    logic [PW-1:0]  payload_q, pay_shift;
    logic [7:0]     pay_byte;
    logic           accept, len_bad, hs;

    always_comb begin
        // Byte idx sits MSB-first, so shifting it to the top exposes it.
        pay_shift  = payload_q << {idx_q, 3'b000};
        pay_byte   = pay_shift[PW-1 -: 8];
        len_bad    = (pkt_len == 8'd0) || (int'(pkt_len) > MAX_LEN);
        send_ready = (state == IDLE);
        accept     = send_ready && send_valid;
        tx_valid   = (state != IDLE);
        hs         = tx_valid && tx_ready;
        tx_data    = '0;
        state_d    = state;
        case (state)
            IDLE: if (accept && !len_bad) state_d = SOF;
            SOF: begin
                tx_data = SOF_BYTE;
                if (hs) state_d = TYPE;
            end
            TYPE: begin
                tx_data = type_q;
                if (hs) state_d = LEN;
            end
            LEN: begin
                tx_data = len_q;
                if (hs) state_d = PAY;
            end
            PAY: begin
                tx_data = pay_byte;
                if (hs && (idx_q + 8'd1 == len_q)) state_d = CHK;
            end
            CHK: begin
                tx_data = sum_q;
                if (hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            type_q    <= '0;
            len_q     <= '0;
            sum_q     <= '0;
            idx_q     <= '0;
            payload_q <= '0;
            pkt_done  <= 1'b0;
            pkt_err   <= 1'b0;
        end else begin
            state    <= state_d;
            pkt_done <= (state == CHK) && hs;
            pkt_err  <= accept && len_bad;
            if (accept) begin
                type_q    <= pkt_type;
                len_q     <= pkt_len;
                payload_q <= payload_bus;
                sum_q     <= pkt_type;
                idx_q     <= '0;
            end
            if (hs) begin
                case (state)
                    LEN: sum_q <= csum_add(sum_q, len_q);
                    PAY: begin
                        sum_q <= csum_add(sum_q, pay_byte);
                        idx_q <= idx_q + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_proto_tx.sv
// Directed bench for proto_tx: frame content, backpressure hold, checksum wrap,
// bad length rejection, full-length loopback parse, back-to-back and mid-frame reset.
module tb_proto_tx;

    localparam int ML = 32;

    logic            clk = 1'b0;
    logic            rst, send_valid, send_ready, tx_valid, tx_ready, pkt_done, pkt_err;
    logic [7:0]      pkt_type, pkt_len, tx_data;
    logic [8*ML-1:0] payload_bus;

    int              checks = 0;
    int              errors = 0;
    int              done_cnt = 0;
    logic [7:0]      cap[$];
    logic [15:0]     bp_pat = 16'b1011_0010_0110_1100;
    logic            prev_stall = 1'b0;
    logic [7:0]      prev_data = 8'h00;

    always #5 clk = ~clk;

    proto_tx #(.MAX_LEN(ML)) dut (
        .clk        (clk),
        .rst        (rst),
        .send_valid (send_valid),
        .send_ready (send_ready),
        .pkt_type   (pkt_type),
        .pkt_len    (pkt_len),
        .payload_bus(payload_bus),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .pkt_done   (pkt_done),
        .pkt_err    (pkt_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] getb(input logic [8*ML-1:0] pb, input int k);
        return 8'(pb >> (8 * (ML - 1 - k)));
    endfunction

    function automatic logic [8*ML-1:0] putb(input logic [8*ML-1:0] pb, input int k,
                                             input logic [7:0] v);
        return pb | ({{(8*ML-8){1'b0}}, v} << (8 * (ML - 1 - k)));
    endfunction

    // Link monitor: records every consumed byte and checks hold-under-stall.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) cap.push_back(tx_data);
            if (pkt_done) done_cnt++;
        end
        prev_stall = !rst && tx_valid && !tx_ready;
        prev_data  = tx_data;
    end

    task automatic send(input logic [7:0] t, input logic [7:0] l, input logic [8*ML-1:0] pb);
        pkt_type    = t;
        pkt_len     = l;
        payload_bus = pb;
        send_valid  = 1'b1;
        @(posedge clk); #1;
        send_valid  = 1'b0;
        pkt_type    = 8'h5E;
        pkt_len     = 8'h07;
        payload_bus = '1;
    endtask

    task automatic run(input bit bp, input bit poke, input int budget, output int n);
        n = 0;
        while (pkt_done !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (bp) tx_ready = bp_pat[4'(n)];
            if (poke && n == 2) begin
                send_valid = 1'b1;
                pkt_len    = 8'd3;
                check("busy_ready", 32'(send_ready), 32'd0);
            end
            if (poke && n == 4) send_valid = 1'b0;
        end
        check("frame_done", 32'(pkt_done), 32'd1);
        check("post_done_valid", 32'(tx_valid), 32'd0);
    endtask

    // Receiver-side parse of the captured stream against the packet that was sent.
    task automatic expect_frame(input string tag, input int base, input logic [7:0] t,
                                input logic [7:0] l, input logic [8*ML-1:0] pb);
        logic [7:0] exp[$];
        logic [7:0] s;
        exp.push_back(8'hAA);
        exp.push_back(t);
        exp.push_back(l);
        s = 8'(t + l);
        for (int k = 0; k < int'(l); k++) begin
            exp.push_back(getb(pb, k));
            s = 8'(s + getb(pb, k));
        end
        exp.push_back(s);
        check({tag, "_count"}, 32'(cap.size() - base), 32'(exp.size()));
        for (int k = 0; k < exp.size(); k++)
            if (base + k < cap.size())
                check($sformatf("%s_b%0d", tag, k), 32'(cap[base + k]), 32'(exp[k]));
    endtask

    initial begin
        int n, base, dsnap;
        logic [8*ML-1:0] pb, pb2;

        rst = 1'b1; send_valid = 1'b0; tx_ready = 1'b0;
        pkt_type = '0; pkt_len = '0; payload_bus = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_pkt_done", 32'(pkt_done), 32'd0);
        check("rst_pkt_err", 32'(pkt_err), 32'd0);
        check("rst_send_ready", 32'(send_ready), 32'd1);

        // 1: basic frame, no stalls
        pb = '0; pb = putb(pb, 0, 8'h10); pb = putb(pb, 1, 8'h20);
        tx_ready = 1'b1; base = cap.size(); dsnap = done_cnt;
        send(8'h01, 8'd2, pb);
        check("t1_first_valid", 32'(tx_valid), 32'd1);
        check("t1_first_data", 32'(tx_data), 32'hAA);
        run(1'b0, 1'b0, 200, n);
        check("t1_cycles", 32'(n), 32'd6);
        expect_frame("t1", base, 8'h01, 8'd2, pb);
        if (cap.size() == base + 6) check("t1_chk", 32'(cap[base + 5]), 32'h33);
        @(posedge clk); #1;
        check("t1_done_once", 32'(done_cnt - dsnap), 32'd1);

        // 2: same packet under backpressure with a busy-time request poke
        base = cap.size();
        tx_ready = bp_pat[0];
        send(8'h01, 8'd2, pb);
        run(1'b1, 1'b1, 200, n);
        expect_frame("t2", base, 8'h01, 8'd2, pb);
        tx_ready = 1'b1;
        @(posedge clk); #1;

        // 3: checksum wrap
        pb = '0; pb = putb(pb, 0, 8'h02);
        base = cap.size();
        send(8'hFF, 8'd1, pb);
        run(1'b0, 1'b0, 200, n);
        check("t3_cycles", 32'(n), 32'd5);
        expect_frame("t3", base, 8'hFF, 8'd1, pb);
        if (cap.size() == base + 5) check("t3_chk", 32'(cap[base + 4]), 32'h02);
        @(posedge clk); #1;

        // 4: bad lengths rejected
        base = cap.size();
        send(8'h07, 8'd0, pb);
        check("t4a_err", 32'(pkt_err), 32'd1);
        check("t4a_valid", 32'(tx_valid), 32'd0);
        check("t4a_ready", 32'(send_ready), 32'd1);
        @(posedge clk); #1;
        check("t4a_err_pulse", 32'(pkt_err), 32'd0);
        send(8'h07, 8'd33, pb);
        check("t4b_err", 32'(pkt_err), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("t4b_valid", 32'(tx_valid), 32'd0);
            check("t4b_ready", 32'(send_ready), 32'd1);
            @(posedge clk); #1;
        end
        check("t4b_err_pulse", 32'(pkt_err), 32'd0);
        check("t4_no_bytes", 32'(cap.size() - base), 32'd0);

        // 5: full-length frame, then back-to-back request on the pkt_done cycle
        pb = '0;
        for (int k = 0; k < ML; k++) pb = putb(pb, k, 8'(k));
        pb2 = '0; pb2 = putb(pb2, 0, 8'h07); pb2 = putb(pb2, 1, 8'h08); pb2 = putb(pb2, 2, 8'h09);
        base = cap.size();
        send(8'h5A, 8'd32, pb);
        run(1'b0, 1'b0, 200, n);
        check("t5_cycles", 32'(n), 32'd36);
        expect_frame("t5a", base, 8'h5A, 8'd32, pb);
        check("t5_b2b_ready", 32'(send_ready), 32'd1);
        base = cap.size();
        send(8'h3C, 8'd3, pb2);
        check("t5_b2b_valid", 32'(tx_valid), 32'd1);
        check("t5_b2b_data", 32'(tx_data), 32'hAA);
        run(1'b0, 1'b0, 200, n);
        expect_frame("t5b", base, 8'h3C, 8'd3, pb2);
        if (cap.size() == base + 7) check("t5b_chk", 32'(cap[base + 6]), 32'h57);
        @(posedge clk); #1;

        // 6: reset after the third payload byte is consumed
        pb = '0;
        for (int k = 0; k < 8; k++) pb = putb(pb, k, 8'(8'h80 + k));
        base = cap.size();
        send(8'h11, 8'd8, pb);
        repeat (6) @(posedge clk);
        #1;
        check("t6_pre_data", 32'(tx_data), 32'h83);
        rst = 1'b1;
        dsnap = done_cnt;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_valid", 32'(tx_valid), 32'd0);
        check("t6_done", 32'(pkt_done), 32'd0);
        check("t6_ready", 32'(send_ready), 32'd1);
        check("t6_aborted_bytes", 32'(cap.size() - base), 32'd6);
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_done", 32'(done_cnt - dsnap), 32'd0);
        pb2 = '0; pb2 = putb(pb2, 0, 8'hAB); pb2 = putb(pb2, 1, 8'hCD);
        base = cap.size();
        send(8'h42, 8'd2, pb2);
        run(1'b0, 1'b0, 200, n);
        expect_frame("t6", base, 8'h42, 8'd2, pb2);
        if (cap.size() == base + 6) check("t6_chk", 32'(cap[base + 5]), 32'hBC);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
